// File: rtl/ct_arb_pkg.sv
// Shared types and sizing constants for the ciphertext-memory read arbiter.
package ct_arb_pkg;

  // Largest supported core count; owner ids are sized for it.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ID_W    = $clog2(MAX_REQ);

  // One stage of the in-flight read pipe.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/ct_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
  import ct_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned      idx;
    logic [N_REQ-1:0] sel;
    gnt    = '0;
    any    = 1'b0;
    win_id = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      sel = N_REQ'(1) << idx;
      if (!any && |(req & sel)) begin
        any    = 1'b1;
        gnt    = sel;
        win_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ct_arbiter.sv
// Round-robin arbiter sharing the ct_mem read port between crack cores, with
// owner tracking through the memory read latency.
module ct_arbiter
  import ct_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rddata
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  pipe_entry_t      pipe_q [RD_LAT];
  logic [N_REQ-1:0] req_act;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [ID_W-1:0]  win_id;

  // No grants while reset is held.
  assign req_act = req & {N_REQ{rst_n}};

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_act),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .any    (pick_any),
    .win_id (win_id)
  );

  assign gnt     = pick_gnt;
  assign rd_data = mem_rddata;

  // Address mux: one-hot grant selects the winner's address, zero when idle.
  always_comb begin
    mem_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) mem_addr = addr[i*AW +: AW];
    end
  end

  // Priority moves just past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (pick_any) begin
      ptr_d = (32'(win_id) + 1 == N_REQ) ? '0 : win_id + ID_W'(1);
    end
  end

  // Pointer and in-flight pipe registers; reset drops every outstanding read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= '{valid: pick_any, id: win_id};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Return strobe to the owner of the read leaving the pipe; silent during reset.
  always_comb begin
    rd_valid = '0;
    if (rst_n && pipe_q[RD_LAT-1].valid) begin
      rd_valid = N_REQ'(1) << pipe_q[RD_LAT-1].id;
    end
  end

endmodule
